// File: rtl/moore_pattern_detector.sv
// rtl/moore_pattern_detector.sv - parametrised Moore sequence detector with saturating hit counter
//
// Scans a qualified symbol stream for a programmable DEPTH-symbol pattern.
// Ports:
//   Clock        system clock, rising edge
//   Reset        synchronous, active-low reset (highest priority)
//   Enable       run; low forces IDLE and clears the history window
//   Data_Valid   qualifier for Data_In
//   Data_In      incoming symbol (DATA_W bits)
//   Pattern      target sequence, slice 0 = oldest symbol
//   Clear_Count  synchronous clear of Match_Count (wins over increment)
//   Data_Out     high only while in MATCH
//   State_Out    current state code (IDLE=0, FILL=1, ARMED=2, MATCH=3)
//   Match_Count  saturating count of MATCH entries
module moore_pattern_detector #(
    parameter int DATA_W  = 2,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 8,
    parameter int OVERLAP = 1
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Enable,
    input  logic                    Data_Valid,
    input  logic [DATA_W-1:0]       Data_In,
    input  logic [DEPTH*DATA_W-1:0] Pattern,
    input  logic                    Clear_Count,
    output logic                    Data_Out,
    output logic [2:0]              State_Out,
    output logic [CNT_W-1:0]        Match_Count
);

    localparam int HW = DEPTH * DATA_W;
    localparam int FW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [FW-1:0]    FILL_LAST = FW'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_ARMED = 3'd2,
        S_MATCH = 3'd3
    } state_t;

    state_t         state;
    logic [HW-1:0]  history;
    logic [FW-1:0]  fill_cnt;
    logic [HW-1:0]  shifted;
    logic           hit;
    logic           enter_match;

    // Newest symbol lives in the top slice so the window lines up with Pattern.
    assign shifted = {Data_In, history[HW-1:DATA_W]};
    assign hit     = (shifted == Pattern);

    // Qualifies the edge that enters or re-enters MATCH; drives the counter.
    always_comb begin
        enter_match = 1'b0;
        if (Reset && Enable && Data_Valid && hit) begin
            case (state)
                S_FILL:  enter_match = (fill_cnt == FILL_LAST);
                S_ARMED: enter_match = 1'b1;
                S_MATCH: enter_match = (OVERLAP != 0);
                default: enter_match = 1'b0;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state    <= S_IDLE;
            history  <= '0;
            fill_cnt <= '0;
        end else if (!Enable) begin
            state    <= S_IDLE;
            history  <= '0;
            fill_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Data_In is ignored on the cycle IDLE is left.
                    state    <= S_FILL;
                    fill_cnt <= '0;
                end
                S_FILL: begin
                    if (Data_Valid) begin
                        history <= shifted;
                        if (fill_cnt == FILL_LAST) begin
                            state <= hit ? S_MATCH : S_ARMED;
                        end else begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                    end
                end
                S_ARMED: begin
                    if (Data_Valid) begin
                        history <= shifted;
                        if (hit) state <= S_MATCH;
                    end
                end
                S_MATCH: begin
                    if (OVERLAP != 0) begin
                        if (Data_Valid) history <= shifted;
                        state <= (Data_Valid && hit) ? S_MATCH : S_ARMED;
                    end else begin
                        // Non-overlapping: demand DEPTH fresh symbols before the next compare.
                        state <= S_FILL;
                        if (Data_Valid) begin
                            history  <= shifted;
                            fill_cnt <= FW'(1);
                        end else begin
                            fill_cnt <= '0;
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    history  <= '0;
                    fill_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            Match_Count <= '0;
        end else if (Clear_Count) begin
            Match_Count <= '0;
        end else if (enter_match && (Match_Count != CNT_MAX)) begin
            Match_Count <= Match_Count + 1'b1;
        end
    end

    assign Data_Out  = (state == S_MATCH);
    assign State_Out = state;

endmodule

// File: tb/tb_moore_pattern_detector.sv
// tb/tb_moore_pattern_detector.sv - self-checking bench for moore_pattern_detector
module tb_moore_pattern_detector;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       valid = 1'b0;
    logic [1:0] din = 2'd0;
    logic [7:0] pattern = 8'h1E;
    logic       clr = 1'b0;

    logic       out_a, out_b, out_c;
    logic [2:0] st_a, st_b, st_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // a: overlapping, b: non-overlapping, c: overlapping with a 2-bit counter
    moore_pattern_detector #(.DATA_W(2), .DEPTH(4), .CNT_W(8), .OVERLAP(1)) dut_a (
        .Clock(clk), .Reset(rst_n), .Enable(en), .Data_Valid(valid), .Data_In(din),
        .Pattern(pattern), .Clear_Count(clr), .Data_Out(out_a), .State_Out(st_a), .Match_Count(cnt_a));
    moore_pattern_detector #(.DATA_W(2), .DEPTH(4), .CNT_W(8), .OVERLAP(0)) dut_b (
        .Clock(clk), .Reset(rst_n), .Enable(en), .Data_Valid(valid), .Data_In(din),
        .Pattern(pattern), .Clear_Count(clr), .Data_Out(out_b), .State_Out(st_b), .Match_Count(cnt_b));
    moore_pattern_detector #(.DATA_W(2), .DEPTH(4), .CNT_W(2), .OVERLAP(1)) dut_c (
        .Clock(clk), .Reset(rst_n), .Enable(en), .Data_Valid(valid), .Data_In(din),
        .Pattern(pattern), .Clear_Count(clr), .Data_Out(out_c), .State_Out(st_c), .Match_Count(cnt_c));

    // Reference model: list of accepted symbols plus, per instance, how many
    // symbols have arrived since the window was (re)started.
    bit m_run;
    int sym_q[$];
    int m_cnt[3];
    bit m_hit[3];
    int m_mc[3];
    int ovl[3]  = '{1, 0, 1};
    int cmax[3] = '{255, 255, 3};

    function automatic bit window_match();
        logic [7:0] p;
        int n;
        p = pattern;
        n = sym_q.size();
        if (n < 4) return 1'b0;
        for (int i = 0; i < 4; i++)
            if (sym_q[n-4+i] != int'(p[i*2 +: 2])) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        bit wm;
        if (!rst_n) begin
            m_run = 0;
            sym_q.delete();
            for (int k = 0; k < 3; k++) begin
                m_cnt[k] = 0; m_hit[k] = 0; m_mc[k] = 0;
            end
        end else if (!en || !m_run) begin
            m_run = en;
            sym_q.delete();
            for (int k = 0; k < 3; k++) begin
                m_cnt[k] = 0; m_hit[k] = 0;
                if (clr) m_mc[k] = 0;
            end
        end else begin
            if (valid) sym_q.push_back(int'(din));
            while (sym_q.size() > 4) void'(sym_q.pop_front());
            wm = window_match();
            for (int k = 0; k < 3; k++) begin
                bit h;
                h = 0;
                if (ovl[k] == 0 && m_hit[k]) begin
                    m_cnt[k] = valid ? 1 : 0;
                end else if (valid) begin
                    m_cnt[k]++;
                    h = (m_cnt[k] >= 4) && wm;
                end
                if (h && ovl[k] == 0) m_cnt[k] = 0;
                m_hit[k] = h;
                if (clr) m_mc[k] = 0;
                else if (h && m_mc[k] < cmax[k]) m_mc[k]++;
            end
        end
    endtask

    function automatic int exp_state(int k);
        if (!m_run) return 0;
        if (m_hit[k]) return 3;
        if (m_cnt[k] < 4) return 1;
        return 2;
    endfunction

    task automatic check(string name, int actual, int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, actual, required, $time);
        end
    endtask

    task automatic compare_all();
        check("a.out",   int'(out_a), int'(m_hit[0]));
        check("a.state", int'(st_a),  exp_state(0));
        check("a.count", int'(cnt_a), m_mc[0]);
        check("b.out",   int'(out_b), int'(m_hit[1]));
        check("b.state", int'(st_b),  exp_state(1));
        check("b.count", int'(cnt_b), m_mc[1]);
        check("c.out",   int'(out_c), int'(m_hit[2]));
        check("c.state", int'(st_c),  exp_state(2));
        check("c.count", int'(cnt_c), m_mc[2]);
    endtask

    task automatic tick(bit r, bit e, bit v, int d, bit c);
        rst_n = r; en = e; valid = v; din = 2'(d); clr = c;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic send(int d);
        tick(1, 1, 1, d, 0);
    endtask

    task automatic restart(logic [7:0] p);
        pattern = p;
        tick(0, 0, 0, 0, 0);
        tick(1, 1, 0, 0, 0);
    endtask

    typedef struct {
        bit r, e, v;
        int d;
        int x_out, x_state, x_cnt;
    } vec_t;

    vec_t vecs[8];
    int pulses_a, pulses_b, run_a, max_run_a;
    logic [2:0] st_save;
    logic [7:0] cnt_save;
    logic       out_save;

    initial begin
        // Reset, then 2,3,1,0 against 8'h1E on the overlapping instance.
        vecs[0] = '{0, 0, 0, 0, 0, 0, 0};
        vecs[1] = '{0, 1, 1, 2, 0, 0, 0};
        vecs[2] = '{1, 1, 0, 0, 0, 1, 0};
        vecs[3] = '{1, 1, 1, 2, 0, 1, 0};
        vecs[4] = '{1, 1, 1, 3, 0, 1, 0};
        vecs[5] = '{1, 1, 1, 1, 0, 1, 0};
        vecs[6] = '{1, 1, 1, 0, 1, 3, 1};
        vecs[7] = '{1, 1, 0, 3, 0, 2, 1};
        pattern = 8'h1E;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            tick(vecs[i].r, vecs[i].e, vecs[i].v, vecs[i].d, 0);
            check($sformatf("vec%0d.out", i),   int'(out_a), vecs[i].x_out);
            check($sformatf("vec%0d.state", i), int'(st_a),  vecs[i].x_state);
            check($sformatf("vec%0d.count", i), int'(cnt_a), vecs[i].x_cnt);
        end

        // Eight consecutive 1s against 8'h55, then a sixth match with Clear_Count.
        restart(8'h55);
        pulses_a = 0; pulses_b = 0; run_a = 0; max_run_a = 0;
        for (int i = 0; i < 8; i++) begin
            send(1);
            pulses_a += int'(out_a);
            pulses_b += int'(out_b);
            run_a = out_a ? run_a + 1 : 0;
            if (run_a > max_run_a) max_run_a = run_a;
        end
        check("ovl.pulses", pulses_a, 5);
        check("ovl.run", max_run_a, 5);
        check("ovl.count", int'(cnt_a), 5);
        check("novl.pulses", pulses_b, 2);
        check("novl.count", int'(cnt_b), 2);
        check("sat.count", int'(cnt_c), 3);
        tick(1, 1, 1, 1, 1);
        check("clr.count", int'(cnt_c), 0);
        check("clr.out", int'(out_c), 1);
        check("clr.state", int'(st_c), 3);

        // Gaps carry Data_In=3 but must not be accepted.
        restart(8'h1E);
        pulses_a = 0;
        send(2); pulses_a += int'(out_a);
        tick(1, 1, 0, 3, 0); pulses_a += int'(out_a);
        send(3); pulses_a += int'(out_a);
        tick(1, 1, 0, 3, 0); pulses_a += int'(out_a);
        tick(1, 1, 0, 3, 0); pulses_a += int'(out_a);
        send(1); pulses_a += int'(out_a);
        send(0);
        check("gap.out", int'(out_a), 1);
        check("gap.early", pulses_a, 0);
        check("gap.count", int'(cnt_a), 1);

        // Dropping Enable breaks the sequence.
        restart(8'h1E);
        send(2); send(3);
        tick(1, 0, 1, 1, 0);
        check("en.state", int'(st_a), 0);
        tick(1, 1, 0, 0, 0);
        send(1); send(0);
        check("en.nomatch", int'(cnt_a), 0);
        send(2); send(3); send(1); send(0);
        check("en.match", int'(out_a), 1);
        check("en.count", int'(cnt_a), 1);

        // Reset pulse between edges is ignored; the next edge sees MATCH continue to ARMED.
        out_save = out_a; st_save = st_a; cnt_save = cnt_a;
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        #1;
        check("glitch.out", int'(out_a), int'(out_save));
        check("glitch.state", int'(st_a), int'(st_save));
        check("glitch.count", int'(cnt_a), int'(cnt_save));
        tick(1, 1, 0, 0, 0);
        check("glitch.armed", int'(st_a), 2);
        send(2); send(3); send(1); send(0);
        check("rst.pre", int'(st_a), 3);
        tick(0, 1, 1, 2, 0);
        check("rst.out", int'(out_a), 0);
        check("rst.state", int'(st_a), 0);
        check("rst.count", int'(cnt_a), 0);

        // Randomised traffic against the model.
        restart(8'h55);
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] p;
            int d;
            if ($urandom_range(0, 99) == 0) begin
                case ($urandom_range(0, 2))
                    0: pattern = 8'h55;
                    1: pattern = 8'h1E;
                    default: pattern = 8'($urandom);
                endcase
            end
            p = pattern;
            d = $urandom_range(0, 1) ? int'(p[(i % 4) * 2 +: 2]) : int'($urandom_range(0, 3));
            tick($urandom_range(0, 299) != 0, $urandom_range(0, 59) != 0,
                 $urandom_range(0, 3) != 0, d, $urandom_range(0, 79) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
